// File: rtl/uart_tx_mmio_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_mmio_if
// Purpose  : CPU data-bus slice seen by the memory-mapped UART transmitter.
//            The CPU side (address decoder + load/store unit) drives the
//            master modport; the peripheral uses the slave modport.
// Ports    : cs     - peripheral select from the address decoder
//            we     - write strobe
//            re     - read strobe
//            addr   - byte offset within the peripheral (addr[2] decoded)
//            wdata  - store data (only [7:0] used)
//            rdata  - combinational read data, zero when not selected
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_mmio_if;
  logic        cs;
  logic        we;
  logic        re;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output cs, output we, output re, output addr, output wdata,
                  input  rdata);
  modport slave  (input  cs, input  we, input  re, input  addr, input  wdata,
                  output rdata);
endinterface
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_mmio
// Purpose  : Memory-mapped 8N1 UART transmitter with a TX FIFO.
//            DATA (addr[2]=0) write pushes a byte; STATUS (addr[2]=1) read
//            returns {overflow, full, empty, tx_busy, ~full} and clears the
//            sticky overflow flag.
// Ports    : clk     - system clock
//            rst     - asynchronous, active-low reset
//            bus     - CPU bus slice (slave modport)
//            txd     - registered serial output, idle high
//            tx_busy - high while a frame is on the line
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_mmio #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_mmio_if.slave        bus,
  output logic                 txd,
  output logic                 tx_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam logic [15:0]      BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] DEPTH_C     = (FIFO_AW + 1)'(FIFO_DEPTH);

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  state_t             state_q, state_d;
  logic [15:0]        baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               txd_q, txd_d;

  logic full, empty, push_req, push_ok, pop, stat_rd;
  logic [31:0] status;
  logic unused_bus_bits;

  assign unused_bus_bits = ^{bus.wdata[31:8], bus.addr[1:0]};

  // --------------------------------------------------------------------------
  // Bus decode and FIFO bookkeeping
  // --------------------------------------------------------------------------
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign push_req = bus.cs & bus.we & ~bus.addr[2];
  assign stat_rd  = bus.cs & bus.re &  bus.addr[2];
  assign pop      = (state_q == S_IDLE) & ~empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO
  // still lands and is not counted as a drop.
  assign push_ok  = push_req & (~full | pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push_ok) wptr_d = wptr_q + FIFO_AW'(1);
    if (pop)     rptr_d = rptr_q + FIFO_AW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
      default: count_d = count_q;
    endcase
    // Drop beats clear when both land on the same edge.
    if (push_req & full & ~pop) ovf_d = 1'b1;
    else if (stat_rd)           ovf_d = 1'b0;
  end

  // Storage array carries no reset; only the pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= bus.wdata[7:0];
  end

  // --------------------------------------------------------------------------
  // Serialiser FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = 1'b1;
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (pop) begin
          shift_d = mem_q[rptr_q];
          baud_d  = BAUD_RELOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        txd_d = 1'b0;
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_DATA: begin
        txd_d = shift_q[0];
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_STOP: begin
        txd_d = 1'b1;
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign tx_busy = (state_q != S_IDLE);
  assign txd     = txd_q;
  assign status  = {27'b0, ovf_q, full, empty, tx_busy, ~full};
  // DATA reads return zero; zero when unselected so peripherals can be OR-ed.
  assign bus.rdata = stat_rd ? status : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_mmio
// Purpose  : Self-checking bench for uart_tx_mmio. Bytes accepted by the
//            FIFO are queued as expected values; a UART receiver model
//            decodes txd and compares each received byte against the queue.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_mmio;
  localparam int CPB   = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic txd, tx_busy;

  uart_tx_mmio_if bus_if ();

  uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .FIFO_AW(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_if),
    .txd     (txd),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  int         checks  = 0;
  int         errors  = 0;
  int         cyc     = 0;
  int         rst_gen = 0;
  logic [7:0] sb_q[$];
  int         rx_starts[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model: samples each bit at its centre on negative edges.
  initial begin : rx_model
    int         gen;
    logic [7:0] b;
    logic       start_ok;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && txd === 1'b0) begin
        gen = rst_gen;
        b = 8'h00;
        rx_starts.push_back(cyc);
        repeat (CPB / 2) @(negedge clk);
        start_ok = (txd === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        if (gen == rst_gen && rst === 1'b1) begin
          checks++;
          if (txd !== 1'b1 || !start_ok) begin
            errors++;
            $display("FAIL rx_framing: byte %02h stop=%b start_ok=%b, required stop=1 start_ok=1",
                     b, txd, start_ok);
          end
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL rx_unexpected: received %02h, required no frame", b);
          end else begin
            exp_b = sb_q.pop_front();
            if (b !== exp_b) begin
              errors++;
              $display("FAIL rx_data: received %02h, required %02h", b, exp_b);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_if.cs = 1'b1; bus_if.we = 1'b1; bus_if.re = 1'b0;
    bus_if.addr = a; bus_if.wdata = {24'h5A5A5A, d};
    @(posedge clk);
    #1;
    bus_if.cs = 1'b0; bus_if.we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic cs_v, output logic [31:0] d);
    @(negedge clk);
    bus_if.cs = cs_v; bus_if.re = 1'b1; bus_if.we = 1'b0; bus_if.addr = a;
    #1;
    d = bus_if.rdata;
    @(posedge clk);
    #1;
    bus_if.cs = 1'b0; bus_if.re = 1'b0;
  endtask

  task automatic wait_drained();
    logic [31:0] s;
    logic        done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bus_read(3'd4, 1'b1, s);
      if (s == 32'h5) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: status %08h, required 00000005", s);
    end
  endtask

  task automatic test_reset();
    bus_if.cs = 1'b0; bus_if.we = 1'b0; bus_if.re = 1'b0;
    bus_if.addr = 3'd0; bus_if.wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (txd !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: txd=%b busy=%b, required txd=1 busy=0", txd, tx_busy);
    end
    bus_if.cs = 1'b1; bus_if.re = 1'b1; bus_if.addr = 3'd4;
    #1;
    checks++;
    if (bus_if.rdata !== 32'h5) begin
      errors++;
      $display("FAIL reset_status: rdata %08h, required 00000005", bus_if.rdata);
    end
    bus_if.cs = 1'b0; bus_if.re = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Store edge is E0; start bit appears after E2, busy spans E1..E40.
  task automatic test_single_frame();
    logic [7:0] byte_v;
    logic       exp_txd, exp_busy;
    byte_v = 8'hA5;
    sb_q.push_back(byte_v);
    bus_write(3'd0, byte_v);
    for (int k = 1; k <= 46; k++) begin
      @(posedge clk);
      #1;
      if (k < 2)                   exp_txd = 1'b1;
      else if (k < 2 + CPB)        exp_txd = 1'b0;
      else if (k < 2 + 9 * CPB)    exp_txd = byte_v[(k - 2 - CPB) / CPB];
      else                         exp_txd = 1'b1;
      exp_busy = (k >= 1 && k <= 10 * CPB);
      checks++;
      if (txd !== exp_txd || tx_busy !== exp_busy) begin
        errors++;
        $display("FAIL frame_wave k=%0d: txd=%b busy=%b, required txd=%b busy=%b",
                 k, txd, tx_busy, exp_txd, exp_busy);
      end
    end
    wait_drained();
  endtask

  task automatic test_overflow();
    logic [31:0] s;
    for (int i = 0; i < 17; i++) begin
      sb_q.push_back(8'h10 + 8'(i));
      bus_write(3'd0, 8'h10 + 8'(i));
    end
    for (int i = 0; i < 18; i++) bus_write(3'd0, 8'hE0 + 8'(i));
    bus_read(3'd4, 1'b1, s);
    checks++;
    if (s !== 32'h1A) begin
      errors++;
      $display("FAIL ovf_status: rdata %08h, required 0000001a", s);
    end
    bus_read(3'd4, 1'b1, s);
    checks++;
    if (s !== 32'h0A) begin
      errors++;
      $display("FAIL ovf_cleared: rdata %08h, required 0000000a", s);
    end
  endtask

  // FIFO still full from the previous scenario; push lands on the pop edge.
  task automatic test_full_pop();
    logic [31:0] s;
    logic        seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (!tx_busy) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL fullpop_wait: busy=%b, required 0 within 200 cycles", tx_busy);
    end
    bus_if.cs = 1'b1; bus_if.we = 1'b1; bus_if.addr = 3'd0; bus_if.wdata = 32'h000000C3;
    sb_q.push_back(8'hC3);
    @(posedge clk);
    #1;
    bus_if.cs = 1'b0; bus_if.we = 1'b0;
    bus_read(3'd4, 1'b1, s);
    checks++;
    if (s !== 32'h0A) begin
      errors++;
      $display("FAIL fullpop_status: rdata %08h, required 0000000a", s);
    end
    wait_drained();
  endtask

  task automatic test_reads();
    logic [31:0] s;
    bus_read(3'd0, 1'b1, s);
    checks++;
    if (s !== 32'h0) begin
      errors++;
      $display("FAIL read_data_reg: rdata %08h, required 00000000", s);
    end
    bus_read(3'd4, 1'b0, s);
    checks++;
    if (s !== 32'h0) begin
      errors++;
      $display("FAIL read_unselected: rdata %08h, required 00000000", s);
    end
    bus_write(3'd4, 8'h77);
    bus_read(3'd4, 1'b1, s);
    checks++;
    if (s !== 32'h5 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL status_write_ignored: rdata %08h busy=%b, required 00000005 busy=0", s, tx_busy);
    end
  endtask

  // 0xF7 has bit 3 = 0, so txd is low when reset hits.
  task automatic test_reset_midframe();
    logic [31:0] s;
    int          bad;
    bus_write(3'd0, 8'hF7);
    bus_write(3'd0, 8'h99);
    repeat (17) @(posedge clk);
    #1;
    checks++;
    if (txd !== 1'b0 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_bit3: txd=%b busy=%b, required txd=0 busy=1", txd, tx_busy);
    end
    rst_gen++;
    rst = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: txd=%b busy=%b, required txd=1 busy=0", txd, tx_busy);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus_read(3'd4, 1'b1, s);
    checks++;
    if (s !== 32'h5) begin
      errors++;
      $display("FAIL post_reset_status: rdata %08h, required 00000005", s);
    end
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (txd !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL residual_frame: %0d active cycles, required 0", bad);
    end
  endtask

  // Start-to-start spacing of 10*CPB+1 means exactly one idle-high cycle.
  task automatic test_back_to_back();
    logic [7:0] bytes_v [3];
    bytes_v[0] = 8'h00; bytes_v[1] = 8'hFF; bytes_v[2] = 8'h55;
    rx_starts.delete();
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(bytes_v[i]);
      bus_write(3'd0, bytes_v[i]);
    end
    wait_drained();
    checks++;
    if (rx_starts.size() != 3) begin
      errors++;
      $display("FAIL b2b_frames: %0d frames, required 3", rx_starts.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (rx_starts[i] - rx_starts[i-1] != 10 * CPB + 1) begin
          errors++;
          $display("FAIL b2b_spacing %0d: %0d cycles, required %0d",
                   i, rx_starts[i] - rx_starts[i-1], 10 * CPB + 1);
        end
      end
    end
  endtask

  initial begin : main
    test_reset();
    test_single_frame();
    test_overflow();
    test_full_pop();
    test_reads();
    test_reset_midframe();
    test_back_to_back();
    repeat (4) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d bytes never received, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
